// File: rtl/asyn_fifo_pkg.sv
// asyn_fifo_pkg: widths and word type shared by the async FIFO, its producer and its consumer
package asyn_fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int COUNT_WIDTH = 16;
  localparam int SKID_DEPTH = 2;
  typedef logic [DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/fifo_skid_buffer.sv
// fifo_skid_buffer: small circular buffer that re-presents captured FIFO words as a valid/ready stream
module fifo_skid_buffer #(
  parameter int DATA_WIDTH = asyn_fifo_pkg::DATA_WIDTH,
  parameter int SKID_DEPTH = asyn_fifo_pkg::SKID_DEPTH
) (
  input  logic                            r_clk,
  input  logic                            rst,
  input  logic                            push,
  input  logic [DATA_WIDTH-1:0]           push_data,
  input  logic                            pop,
  output logic [$clog2(SKID_DEPTH+1)-1:0] occ,
  output logic                            m_valid,
  output logic [DATA_WIDTH-1:0]           m_data
);
  import asyn_fifo_pkg::*;
  localparam int PW = $clog2(SKID_DEPTH);
  localparam int OW = $clog2(SKID_DEPTH+1);
  logic [DATA_WIDTH-1:0] r_buf [SKID_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [OW-1:0] r_occ;
  // capture on push, release on pop; depth is a power of two so pointers wrap naturally
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) r_buf[i] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (push) begin
        r_buf[r_wptr] <= push_data;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (pop) r_rptr <= r_rptr + PW'(1);
      r_occ <= r_occ + OW'(push) - OW'(pop);
    end
  end
  assign occ     = r_occ;
  assign m_valid = r_occ != '0;
  assign m_data  = r_buf[r_rptr];
endmodule

// File: rtl/fifo_read_stream.sv
// fifo_read_stream: pulls words from the async FIFO read port and streams them out via a skid buffer
module fifo_read_stream #(
  parameter int DATA_WIDTH  = asyn_fifo_pkg::DATA_WIDTH,
  parameter int SKID_DEPTH  = asyn_fifo_pkg::SKID_DEPTH,
  parameter int COUNT_WIDTH = asyn_fifo_pkg::COUNT_WIDTH
) (
  input  logic                   r_clk,
  input  logic                   rst,
  input  logic                   drain_en,
  input  logic                   fifo_empty,
  output logic                   fifo_load,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic [COUNT_WIDTH-1:0] rd_count,
  output logic                   idle
);
  import asyn_fifo_pkg::*;
  localparam int OW = $clog2(SKID_DEPTH+1);
  localparam logic [OW:0] LIMIT = (OW+1)'(SKID_DEPTH);
  logic                   r_inflight;
  logic [COUNT_WIDTH-1:0] r_rd_count;
  logic [OW-1:0]          w_occ;
  logic                   w_pop;
  logic [OW:0]            w_credit;
  assign w_pop    = m_valid & m_ready;
  // slots committed after this edge: buffered + word arriving - word leaving
  assign w_credit = {1'b0, w_occ} + (OW+1)'(r_inflight) - (OW+1)'(w_pop);
  assign fifo_load = ~rst & drain_en & ~fifo_empty & (w_credit < LIMIT);
  // track the FIFO's one-cycle read latency and count delivered words
  always_ff @(posedge r_clk or posedge rst) begin
    if (rst) begin
      r_inflight <= 1'b0;
      r_rd_count <= '0;
    end else begin
      r_inflight <= fifo_load;
      r_rd_count <= r_rd_count + COUNT_WIDTH'(w_pop);
    end
  end
  fifo_skid_buffer #(.DATA_WIDTH(DATA_WIDTH), .SKID_DEPTH(SKID_DEPTH)) u_skid (
    .r_clk     (r_clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_data (fifo_data),
    .pop       (w_pop),
    .occ       (w_occ),
    .m_valid   (m_valid),
    .m_data    (m_data)
  );
  assign rd_count = r_rd_count;
  assign idle     = ~r_inflight & (w_occ == '0);
endmodule
